// File: rtl/serial_fa_sequencer.sv
// Bit-serial adder: one shared full-adder slice adds two WIDTH-bit operands LSB first,
// one bit per clock, with a start/busy/done handshake and a registered result.
module serial_fa_sequencer #(
    parameter int  WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] psum_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic             slice_sum_s;
    logic             slice_carry_s;
    logic             last_bit_s;

    // Half adder: {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    // Full adder slice built from two half adders: {carry, sum}
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        logic [1:0] ha1;
        logic [1:0] ha2;
        ha1 = half_add(x, y);
        ha2 = half_add(ha1[0], c);
        return {ha1[1] | ha2[1], ha2[0]};
    endfunction

    // Shared slice evaluation and last-bit detection
    always_comb begin
        {slice_carry_s, slice_sum_s} = full_add(a_sh_r[0], b_sh_r[0], carry_r);
        last_bit_s                   = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register; busy/done are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy    <= (state_nxt_s != IDLE);
            done    <= (state_nxt_s == DONE);
        end
    end

    // Operand shifters, carry FF, bit counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            psum_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= cin;
                        cnt_r   <= '0;
                        psum_r  <= '0;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                RUN: begin
                    carry_r <= slice_carry_s;
                    psum_r  <= {slice_sum_s, psum_r[WIDTH-1:1]};
                    a_sh_r  <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r  <= {1'b0, b_sh_r[WIDTH-1:1]};
                    cnt_r   <= cnt_r + CNT_W'(1);
                    // Result registers only move on the edge that enters DONE
                    if (last_bit_s) begin
                        sum  <= {slice_sum_s, psum_r[WIDTH-1:1]};
                        cout <= slice_carry_s;
                    end else begin
                        cout <= cout;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_fa_sequencer.sv
// Scoreboard bench for serial_fa_sequencer: a WIDTH=8 and a WIDTH=2 instance share clk/rst
// and are exercised one at a time; expected results come from plain integer addition.
module tb_serial_fa_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, start2 = 1'b0;
    logic [7:0] a8 = 8'd0, b8 = 8'd0;
    logic [1:0] a2 = 2'd0, b2 = 2'd0;
    logic       cin8 = 1'b0, cin2 = 1'b0;
    logic       busy8, done8, cout8, busy2, done2, cout2;
    logic [7:0] sum8;
    logic [1:0] sum2;

    int total = 0;
    int bad   = 0;
    int ncount = 0;
    bit armed = 1'b0;

    typedef struct {
        int         id;
        logic [8:0] exp;
        int         done_at;
    } exp_t;
    exp_t sb_q[$];

    serial_fa_sequencer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_fa_sequencer #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    always #5 clk = ~clk;

    function automatic int wid(input int d);
        return (d == 0) ? 8 : 2;
    endfunction

    // Reference: {cout,sum} = a + b + cin, packed as cout at bit WIDTH
    function automatic logic [8:0] ref_add(input int d, input int x, input int y, input int c);
        int s;
        s = x + y + c;
        return 9'(s & ((1 << (wid(d) + 1)) - 1));
    endfunction

    function automatic logic [8:0] dut_res(input int d);
        return (d == 0) ? {cout8, sum8} : {6'd0, cout2, sum2};
    endfunction

    function automatic logic dut_busy(input int d);
        return (d == 0) ? busy8 : busy2;
    endfunction

    function automatic logic dut_done(input int d);
        return (d == 0) ? done8 : done2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic st, input int x, input int y, input int c);
        if (d == 0) begin
            start8 = st; a8 = 8'(x); b8 = 8'(y); cin8 = 1'(c);
        end else begin
            start2 = st; a2 = 2'(x); b2 = 2'(y); cin2 = 1'(c);
        end
    endtask

    // Wait for IDLE, issue one request, optionally queue its expected result
    task automatic do_op(input int d, input int x, input int y, input int c,
                         input bit push, input bit spur);
        int n;
        n = 0;
        @(negedge clk);
        while (dut_busy(d) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL idle_wait: busy stuck for dut %0d", d);
        end
        @(posedge clk);
        #1;
        drive(d, 1'b1, x, y, c);
        if (push) sb_q.push_back('{d, ref_add(d, x, y, c), ncount + wid(d) + 2});
        @(posedge clk);
        #1;
        drive(d, 1'b0, $urandom, $urandom, $urandom_range(1, 0));
        if (spur) begin
            repeat (2) @(posedge clk);
            #1;
            drive(d, 1'b1, $urandom, $urandom, $urandom_range(1, 0));
            repeat (2) @(posedge clk);
            #1;
            drive(d, 1'b0, $urandom, $urandom, $urandom_range(1, 0));
        end
    endtask

    // Monitor: pops the scoreboard on done, checks result/latency/busy span and result hold
    logic [8:0] held [2];
    int         busy_run [2];
    logic       prev_done [2];
    always @(negedge clk) begin
        ncount++;
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                if (dut_busy(d)) busy_run[d]++;
                else busy_run[d] = 0;
                if (dut_done(d)) begin
                    chk("done_single_cycle", 32'(prev_done[d]), 32'd0);
                    if (sb_q.size() == 0 || sb_q[0].id != d) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: dut %0d result %0h", d, dut_res(d));
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("result", 32'(dut_res(d)), 32'(e.exp));
                        chk("done_latency", 32'(ncount), 32'(e.done_at));
                        chk("busy_span", 32'(busy_run[d]), 32'(wid(d) + 1));
                    end
                    held[d] = dut_res(d);
                end else begin
                    chk("result_hold", 32'(dut_res(d)), 32'(held[d]));
                end
                prev_done[d] = dut_done(d);
                if (rst) begin
                    held[d]     = 9'd0;
                    busy_run[d] = 0;
                end
            end
        end
    end

    initial begin
        int n;
        for (int d = 0; d < 2; d++) begin
            held[d] = 9'd0; busy_run[d] = 0; prev_done[d] = 1'b0;
        end
        // Start and rst together: reset must win
        start8 = 1'b1; a8 = 8'h12; b8 = 8'h34;
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b0;
        rst    = 1'b0;
        armed  = 1'b1;
        @(negedge clk);
        chk("reset_busy8", 32'(busy8), 32'd0);
        chk("reset_done8", 32'(done8), 32'd0);
        chk("reset_res8", 32'(dut_res(0)), 32'd0);
        chk("reset_busy2", 32'(busy2), 32'd0);
        chk("reset_res2", 32'(dut_res(1)), 32'd0);

        do_op(0, 8'h00, 8'h00, 0, 1'b1, 1'b0);
        do_op(0, 8'hFF, 8'h01, 0, 1'b1, 1'b0);
        do_op(0, 8'hA5, 8'h5A, 1, 1'b1, 1'b0);
        do_op(0, 8'h3C, 8'h42, 0, 1'b1, 1'b0);
        do_op(0, 8'h10, 8'h20, 0, 1'b1, 1'b1);

        // Abort mid-run with a one-cycle reset
        do_op(0, 8'hFF, 8'hFF, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_res", 32'(dut_res(0)), 32'd0);
        do_op(0, 8'h7F, 8'h01, 1, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++)
            do_op(0, $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(1, 0),
                  1'b1, (i % 5) == 0);

        // Wait for the 8-bit unit to drain before moving to the 2-bit unit
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            do_op(1, int'(v[4:3]), int'(v[2:1]), int'(v[0]), 1'b1, 1'b0);
        end

        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
